// File: rtl/wb_dbg_master.sv
// rtl/wb_dbg_master.sv - UART byte-stream command decoder driving single 32-bit Wishbone cycles
module wb_dbg_master #(
    parameter int timeout = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_dat,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_dat,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);
    localparam int TW = $clog2(timeout + 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP, S_SEND} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_cnt;
    logic [TW-1:0] r_tmr;
    logic        r_we, r_we_o, r_cyc, r_tx_valid;
    logic [3:0]  r_sel;
    logic [31:0] r_adr, r_wdat;
    logic [23:0] r_rdata;
    logic [7:0]  r_tx_dat;
    logic        w_rx_fire, w_tx_fire, w_last, w_load_resp;
    logic [7:0]  w_resp;

    assign rx_ready  = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_rx_fire = rx_valid & rx_ready;
    assign w_tx_fire = r_tx_valid & tx_ready;
    assign w_last    = (r_cnt == 2'd3);

    assign tx_dat   = r_tx_dat;
    assign tx_valid = r_tx_valid;
    assign wb_adr_o = r_adr & 32'hFFFF_FFFC;
    assign wb_dat_o = r_wdat;
    assign wb_sel_o = r_sel;
    assign wb_we_o  = r_we_o;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load_resp = 1'b0;
        w_resp      = 8'h00;
        case (r_state)
            S_IDLE: if (w_rx_fire) begin
                if (rx_dat == 8'h57 || rx_dat == 8'h52) begin
                    w_next = S_ADDR;
                end else begin
                    w_next      = S_RESP;
                    w_load_resp = 1'b1;
                    w_resp      = 8'h3F;
                end
            end
            S_ADDR: if (w_rx_fire && w_last) w_next = r_we ? S_DATA : S_BUS;
            S_DATA: if (w_rx_fire && w_last) w_next = S_BUS;
            S_BUS: begin
                // err wins over a simultaneous ack
                if (wb_err_i) begin
                    w_next      = S_RESP;
                    w_load_resp = 1'b1;
                    w_resp      = 8'h21;
                end else if (wb_ack_i) begin
                    if (r_we) begin
                        w_next      = S_RESP;
                        w_load_resp = 1'b1;
                        w_resp      = 8'h2E;
                    end else begin
                        w_next = S_SEND;
                    end
                end else if (r_tmr == TW'(timeout - 1)) begin
                    w_next      = S_RESP;
                    w_load_resp = 1'b1;
                    w_resp      = 8'h21;
                end
            end
            S_RESP: if (w_tx_fire) w_next = S_IDLE;
            S_SEND: if (w_tx_fire && w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= 2'd0;
            r_tmr      <= '0;
            r_we       <= 1'b0;
            r_we_o     <= 1'b0;
            r_cyc      <= 1'b0;
            r_sel      <= 4'h0;
            r_tx_valid <= 1'b0;
            r_adr      <= 32'h0;
            r_wdat     <= 32'h0;
            r_rdata    <= 24'h0;
            r_tx_dat   <= 8'h00;
        end else begin
            r_cyc      <= (w_next == S_BUS);
            r_we_o     <= (w_next == S_BUS) && r_we;
            r_sel      <= (w_next == S_BUS) ? 4'hF : 4'h0;
            r_tx_valid <= (w_next == S_RESP) || (w_next == S_SEND);
            r_tmr      <= (r_state == S_BUS) ? r_tmr + 1'b1 : '0;
            if (w_rx_fire && r_state == S_IDLE) r_we <= (rx_dat == 8'h57);
            // one 2-bit counter serves address, data and read-byte phases; it wraps to 0 at each phase end
            if ((w_rx_fire && (r_state == S_ADDR || r_state == S_DATA)) ||
                (w_tx_fire && r_state == S_SEND))
                r_cnt <= r_cnt + 1'b1;
            if (w_rx_fire && r_state == S_ADDR) r_adr  <= {r_adr[23:0], rx_dat};
            if (w_rx_fire && r_state == S_DATA) r_wdat <= {r_wdat[23:0], rx_dat};
            if (w_load_resp) begin
                r_tx_dat <= w_resp;
            end else if (r_state == S_BUS && w_next == S_SEND) begin
                r_tx_dat <= wb_dat_i[31:24];
                r_rdata  <= wb_dat_i[23:0];
            end else if (w_tx_fire && r_state == S_SEND) begin
                r_tx_dat <= r_rdata[23:16];
                r_rdata  <= {r_rdata[15:0], 8'h00};
            end else if (w_tx_fire) begin
                r_tx_dat <= 8'h00;
            end
        end
    end
endmodule

// File: tb/tb_wb_dbg_master.sv
// tb/tb_wb_dbg_master.sv - scoreboard bench for wb_dbg_master with a scripted Wishbone slave
module tb_wb_dbg_master;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_dat;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_dat;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

    wb_dbg_master #(.timeout(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_dat(tx_dat), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    // mode: 0 ack at cycle 'at', 1 never respond, 2 err at 'at', 3 ack+err at 'at'
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        logic        we;
        int          mode;
        int          at;
        int          len;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] tx_q[$];
    bus_t       cur;
    int         n_checks = 0;
    int         n_fail = 0;
    int         tx_hold = 0;
    int         stall = 0;
    logic [7:0] prev_tx;
    int         cyc_len = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_rx_ready", rx_ready, 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_dat", tx_dat, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_sel", wb_sel_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n = 0;
        logic r = 1'b0;
        rx_dat   = b;
        rx_valid = 1'b1;
        while (!r && n < 200) begin
            @(negedge clk);
            r = rx_ready;
            @(posedge clk);
            n++;
        end
        if (!r) check("rx_accept_timeout", {31'd0, r}, 1);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((tx_q.size() != 0 || bus_q.size() != 0 || wb_cyc_o || tx_valid) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("done_in_time", (n < 2000) ? 32'd1 : 32'd0, 1);
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] a, d;
        a = adr;
        d = dat;
        send_byte(we ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        if (we) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    endtask

    task automatic do_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input int mode, input int at, input int hold);
        bus_t        b;
        logic [31:0] d;
        d       = dat;
        b.adr   = adr & 32'hFFFF_FFFC;
        b.dat   = dat;
        b.rdata = dat;
        b.we    = we;
        b.mode  = mode;
        b.at    = at;
        b.len   = (mode == 1) ? TMO : at;
        bus_q.push_back(b);
        if (mode != 0) tx_q.push_back(8'h21);
        else if (we) tx_q.push_back(8'h2E);
        else for (int i = 3; i >= 0; i--) tx_q.push_back(d[8*i +: 8]);
        tx_hold = hold;
        send_cmd(we, adr, dat);
        check("cyc_after_last_byte", wb_cyc_o, 1);
        wait_done();
    endtask

    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall    = 0;
                tx_ready = 1'b0;
            end else if (tx_valid) begin
                if (stall > 0) check("tx_stable", tx_dat, prev_tx);
                if (stall >= tx_hold) begin
                    tx_ready = 1'b1;
                    if (tx_q.size() == 0) check("tx_unexpected", tx_q.size(), 1);
                    else check("tx_byte", tx_dat, tx_q.pop_front());
                    stall = 0;
                end else begin
                    tx_ready = 1'b0;
                    prev_tx  = tx_dat;
                    stall++;
                end
            end else begin
                if (stall > 0) check("tx_valid_held", tx_valid, 1);
                tx_ready = 1'b0;
                stall    = 0;
            end
        end
    end

    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'hA5A5_A5A5;
        cur      = '{32'h0, 32'h0, 32'h0, 1'b0, 1, 0, TMO};
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                cyc_len  = 0;
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
            end else if (wb_cyc_o) begin
                cyc_len++;
                if (cyc_len == 1) begin
                    if (bus_q.size() == 0) begin
                        check("bus_unexpected", bus_q.size(), 1);
                        cur = '{32'h0, 32'h0, 32'h0, 1'b0, 1, 0, TMO};
                    end else begin
                        cur = bus_q.pop_front();
                    end
                end
                check("bus_adr", wb_adr_o, cur.adr);
                check("bus_we", wb_we_o, cur.we);
                if (cur.we) check("bus_dat", wb_dat_o, cur.dat);
                check("bus_sel", wb_sel_o, 4'hF);
                check("bus_stb", wb_stb_o, 1);
                wb_ack_i = (cur.mode == 0 || cur.mode == 3) && cyc_len == cur.at;
                wb_err_i = (cur.mode == 2 || cur.mode == 3) && cyc_len == cur.at;
                wb_dat_i = wb_ack_i ? cur.rdata : 32'hA5A5_A5A5;
            end else begin
                if (cyc_len > 0) begin
                    check("bus_len", cyc_len, cur.len);
                    check("tx_after_bus", tx_valid, 1);
                    check("sel_idle", wb_sel_o, 0);
                end
                cyc_len  = 0;
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = 32'hA5A5_A5A5;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_dat   = 8'h00;
        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        do_cmd(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 3, 0);
        do_cmd(1'b0, 32'h0000_0008, 32'h1234_5678, 0, 2, 5);

        tx_hold = 0;
        tx_q.push_back(8'h3F);
        send_byte(8'h41);
        wait_done();
        do_cmd(1'b0, 32'h0000_0100, 32'hCAFE_F00D, 0, 1, 0);

        do_cmd(1'b0, 32'h0000_0020, 32'h0, 1, 0, 0);
        do_cmd(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 2, 2, 0);
        do_cmd(1'b1, 32'h0000_0044, 32'h1111_2222, 3, 1, 1);

        send_byte(8'h52);
        send_byte(8'h00);
        apply_reset();
        do_cmd(1'b1, 32'h0000_0200, 32'h5555_AAAA, 0, 1, 0);

        bus_q.push_back('{32'h0000_0300, 32'h0, 32'h0, 1'b0, 1, 0, TMO});
        send_cmd(1'b0, 32'h0000_0300, 32'h0);
        repeat (3) @(posedge clk);
        check("cyc_before_reset", wb_cyc_o, 1);
        apply_reset();
        do_cmd(1'b0, 32'h0000_0304, 32'h8765_4321, 0, 4, 2);

        for (int i = 0; i < 4; i++) begin
            do_cmd(1'($urandom_range(0, 1)), $urandom, $urandom,
                   0, $urandom_range(1, 5), $urandom_range(0, 2));
        end

        check("tx_queue_empty", tx_q.size(), 0);
        check("bus_queue_empty", bus_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
